// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-port unified-memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // Requester identifiers held in the latched port register.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    // Widths sized for the legal parameter ranges (LATENCY <= 15, MAX_STREAK <= 7).
    localparam int CNT_W    = 4;
    localparam int STREAK_W = 3;

    // Saturating increment of the data-grant streak counter.
    function automatic logic [STREAK_W-1:0] streak_sat_inc(
        input logic [STREAK_W-1:0] streak,
        input logic [STREAK_W-1:0] limit
    );
        logic [STREAK_W-1:0] result;
        if (streak >= limit) begin
            result = limit;
        end else begin
            result = streak + 3'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_arbiter_latency_counter.sv
// Busy-cycle counter for one memory access: cleared on grant, advanced while
// the access is in flight, flags the cycle in which the memory is strobed.
module arb_latency_counter
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(LATENCY - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count register: clear has priority so a new grant always restarts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + 4'd1;
        end
    end

    assign tc = (cnt_r == TERMINAL);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sequencing the fetch and data ports onto a single memory instance,
// one access at a time, with fixed latency, data priority and a fetch
// anti-starvation streak limit.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int MAX_STREAK = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    input  logic        halt,
    output logic        ram_en,
    output logic        ram_wr,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        ram_dump,
    output logic        err
);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_STREAK);

    arb_state_t            state_r;
    arb_state_t            state_nxt_s;
    logic [STREAK_W-1:0]   streak_r;
    logic [STREAK_W-1:0]   streak_nxt_s;
    logic                  grant_s;
    logic                  grant_port_s;
    logic                  cnt_en_s;
    logic                  finish_s;
    logic                  tc_s;

    logic                  port_r;
    logic                  wr_r;
    logic [15:0]           addr_r;
    logic [15:0]           wdata_r;
    logic [15:0]           if_rdata_r;
    logic [15:0]           d_rdata_r;
    logic                  if_done_r;
    logic                  d_done_r;
    logic                  err_r;
    logic                  misaligned_s;

    arb_latency_counter #(
        .LATENCY (LATENCY)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant_s),
        .enable (cnt_en_s),
        .tc     (tc_s)
    );

    // FSM state and streak registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            streak_r <= {STREAK_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            streak_r <= streak_nxt_s;
        end
    end

    // Next-state logic: arbitration in IDLE, latency wait in BUSY, one done cycle.
    always_comb begin
        state_nxt_s  = state_r;
        streak_nxt_s = streak_r;
        grant_s      = 1'b0;
        grant_port_s = PORT_IF;
        cnt_en_s     = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (d_req && (!if_req || (streak_r < STREAK_LIMIT))) begin
                    grant_s      = 1'b1;
                    grant_port_s = PORT_D;
                    state_nxt_s  = ST_BUSY;
                    // Streak only grows while fetch is actually being held off.
                    if (if_req) begin
                        streak_nxt_s = streak_sat_inc(streak_r, STREAK_LIMIT);
                    end else begin
                        streak_nxt_s = {STREAK_W{1'b0}};
                    end
                end else if (if_req) begin
                    grant_s      = 1'b1;
                    grant_port_s = PORT_IF;
                    state_nxt_s  = ST_BUSY;
                    streak_nxt_s = {STREAK_W{1'b0}};
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (tc_s) begin
                    finish_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_en_s    = 1'b1;
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Access latch: captured once per grant so memory pins stay stable during BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_r  <= PORT_IF;
            wr_r    <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 16'h0000;
        end else if (grant_s) begin
            port_r <= grant_port_s;
            if (grant_port_s == PORT_D) begin
                wr_r    <= d_wr;
                addr_r  <= d_addr;
                wdata_r <= d_wdata;
            end else begin
                wr_r    <= 1'b0;
                addr_r  <= if_addr;
                wdata_r <= 16'h0000;
            end
        end
    end

    assign misaligned_s = addr_r[0];

    // Completion: done pulses, read-data capture and sticky misalignment error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_done_r  <= 1'b0;
            d_done_r   <= 1'b0;
            if_rdata_r <= 16'h0000;
            d_rdata_r  <= 16'h0000;
            err_r      <= 1'b0;
        end else begin
            if_done_r <= finish_s && (port_r == PORT_IF);
            d_done_r  <= finish_s && (port_r == PORT_D);
            if (finish_s && !wr_r && !misaligned_s) begin
                if (port_r == PORT_D) begin
                    d_rdata_r <= ram_rdata;
                end else begin
                    if_rdata_r <= ram_rdata;
                end
            end
            if (finish_s && misaligned_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Memory strobe is decoded from flops only: last busy cycle of an aligned access.
    assign ram_en    = (state_r == ST_BUSY) && tc_s && !misaligned_s;
    assign ram_wr    = ram_en && wr_r;
    assign ram_addr  = addr_r;
    assign ram_wdata = wdata_r;
    assign ram_dump  = halt || err_r;

    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign if_done   = if_done_r;
    assign d_done    = d_done_r;
    assign err       = err_r;
    assign if_stall  = if_req && !if_done_r;
    assign d_stall   = d_req && !d_done_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int LAT  = 4;
    localparam int MAXS = 3;
    localparam bit P_IF = 1'b0;
    localparam bit P_D  = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_wr, halt;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic [15:0] if_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_done, if_stall, d_done, d_stall, ram_en, ram_wr, ram_dump, err;

    logic        if_req1;
    logic [15:0] if_addr1;
    logic [15:0] if_rdata1, d_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
    logic        if_done1, if_stall1, d_done1, d_stall1, ram_en1, ram_wr1, ram_dump1, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LAT), .MAX_STREAK(MAXS)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall), .halt(halt),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_dump(ram_dump), .err(err)
    );

    mem_arbiter #(.LATENCY(1), .MAX_STREAK(MAXS)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_done(if_done1), .if_stall(if_stall1),
        .d_req(1'b0), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000), .d_rdata(d_rdata1),
        .d_done(d_done1), .d_stall(d_stall1), .halt(1'b0),
        .ram_en(ram_en1), .ram_wr(ram_wr1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata1), .ram_dump(ram_dump1), .err(err1)
    );

    // Memory behind the main instance: untouched words read a fixed pattern.
    logic [15:0] mem [1024];
    bit          written [1024];
    logic        bk_we;
    logic [9:0]  bk_addr;
    logic [15:0] bk_data;

    function automatic logic [15:0] init_val(input logic [9:0] a);
        return ({6'd0, a} * 16'h9E37) ^ 16'h1357;
    endfunction

    always @(posedge clk) begin
        if (bk_we) begin
            mem[bk_addr]     <= bk_data;
            written[bk_addr] <= 1'b1;
        end else if (ram_en && ram_wr) begin
            mem[ram_addr[9:0]]     <= ram_wdata;
            written[ram_addr[9:0]] <= 1'b1;
        end
    end

    assign ram_rdata  = written[ram_addr[9:0]] ? mem[ram_addr[9:0]] : init_val(ram_addr[9:0]);
    assign ram_rdata1 = ram_addr1 ^ 16'h5A5A;

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; if_req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for the done pulse of one port, counting memory strobes.
    task automatic wait_done(input bit port, input int budget, output int cycles,
                             output int en_cnt, output int wr_cnt, output bit seen);
        cycles = 0; en_cnt = 0; wr_cnt = 0; seen = 1'b0;
        while (!seen && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (ram_en) en_cnt++;
            if (ram_en && ram_wr) wr_cnt++;
            if ((port == P_D) ? d_done : if_done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_wr = 1'b1; if_req1 = 1'b0;
        if_addr = 16'hAAAB; d_addr = 16'h5555; d_wdata = 16'hFFFF; halt = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({if_rdata, d_rdata, ram_addr, ram_wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_data: got %h required 0", {if_rdata, d_rdata, ram_addr, ram_wdata});
        end
        checks++;
        if ({if_done, d_done, ram_en, ram_wr, ram_dump, err} !== 6'b000000) begin
            errors++; $display("FAIL reset_ctrl: got %b required 000000", {if_done, d_done, ram_en, ram_wr, ram_dump, err});
        end
        checks++;
        if ({if_stall, d_stall} !== 2'b11) begin
            errors++; $display("FAIL reset_stall: got %b required 11", {if_stall, d_stall});
        end
        checks++;
        if ({if_rdata1, d_rdata1, ram_addr1, ram_wdata1, if_done1, if_stall1, d_done1, d_stall1,
             ram_en1, ram_wr1, ram_dump1, err1} !== 72'h0) begin
            errors++; $display("FAIL reset_dut1: got nonzero outputs on the latency-1 instance");
        end
        if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch_basic();
        bk_we = 1'b1; bk_addr = 10'h010; bk_data = 16'hBEEF;
        @(negedge clk);
        bk_we = 1'b0;
        bk_addr = 10'h020; bk_data = 16'h0000;
        bk_we = 1'b1;
        @(negedge clk);
        bk_we = 1'b0;
        if_req = 1'b1; if_addr = 16'h0010;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            d_addr = 16'($urandom); d_wdata = 16'($urandom);
            #1;
            checks++;
            if (ram_en !== (k == 4)) begin
                errors++; $display("FAIL fetch_ram_en cycle %0d: got %b required %b", k, ram_en, (k == 4));
            end
            checks++;
            if (if_done !== (k == 5)) begin
                errors++; $display("FAIL fetch_done cycle %0d: got %b required %b", k, if_done, (k == 5));
            end
            checks++;
            if (if_stall !== (k <= 4)) begin
                errors++; $display("FAIL fetch_stall cycle %0d: got %b required %b", k, if_stall, (k <= 4));
            end
            if (k >= 1) begin
                checks++;
                if (ram_addr !== 16'h0010) begin
                    errors++; $display("FAIL fetch_ram_addr cycle %0d: got %h required 0010", k, ram_addr);
                end
            end
        end
        checks++;
        if (if_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL fetch_rdata: got %h required beef", if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({if_done, if_stall, ram_en} !== 3'b000) begin
            errors++; $display("FAIL fetch_after: got %b required 000", {if_done, if_stall, ram_en});
        end
    endtask

    task automatic test_write_read();
        int cyc, en, wr;
        bit seen;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        wait_done(P_D, 20, cyc, en, wr, seen);
        checks++;
        if (!seen || cyc != LAT + 1 || en != 1 || wr != 1) begin
            errors++; $display("FAIL write_access: seen=%0d cycles=%0d en=%0d wr=%0d required 1/%0d/1/1", seen, cyc, en, wr, LAT + 1);
        end
        d_req = 1'b0;
        #1;
        checks++;
        if (d_rdata !== 16'h0000) begin
            errors++; $display("FAIL write_no_rdata: got %h required 0000", d_rdata);
        end
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0; d_wdata = 16'hDEAD;
        wait_done(P_D, 20, cyc, en, wr, seen);
        checks++;
        if (!seen || cyc != LAT + 1 || en != 1 || wr != 0) begin
            errors++; $display("FAIL read_access: seen=%0d cycles=%0d en=%0d wr=%0d required 1/%0d/1/0", seen, cyc, en, wr, LAT + 1);
        end
        checks++;
        if (d_rdata !== 16'h1234) begin
            errors++; $display("FAIL read_rdata: got %h required 1234", d_rdata);
        end
        checks++;
        if (if_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL read_if_rdata_kept: got %h required beef", if_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_streak();
        int n, cyc, last, streak_m;
        bit exp_port;
        logic [1:0] exp_dn;
        do_reset();
        if_req = 1'b1; if_addr = 16'h0010; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
        n = 0; cyc = 0; last = 0; streak_m = 0;
        while (n < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (if_done || d_done) begin
                exp_port = (streak_m < MAXS) ? P_D : P_IF;
                streak_m = (exp_port == P_D) ? streak_m + 1 : 0;
                exp_dn = (exp_port == P_D) ? 2'b01 : 2'b10;
                checks++;
                if ({if_done, d_done} !== exp_dn) begin
                    errors++; $display("FAIL streak_order #%0d: got if/d %b required %b", n, {if_done, d_done}, exp_dn);
                end
                checks++;
                if ((cyc - last) != ((n == 0) ? LAT + 1 : LAT + 2)) begin
                    errors++; $display("FAIL streak_spacing #%0d: got %0d required %0d", n, cyc - last, (n == 0) ? LAT + 1 : LAT + 2);
                end
                last = cyc;
                n++;
            end
        end
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL streak_timeout: got %0d completions required 8", n);
        end
        if_req = 1'b0; d_req = 1'b0;
        checks++;
        if ({if_rdata, d_rdata} !== {16'hBEEF, 16'h1234}) begin
            errors++; $display("FAIL streak_rdata: got %h required beef1234", {if_rdata, d_rdata});
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        int cyc, en, wr;
        bit seen;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0021;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL misalign_pre_err: got %b required 0", err);
        end
        wait_done(P_D, 20, cyc, en, wr, seen);
        checks++;
        if (!seen || cyc != LAT + 1 || en != 0) begin
            errors++; $display("FAIL misalign_access: seen=%0d cycles=%0d en=%0d required 1/%0d/0", seen, cyc, en, LAT + 1);
        end
        checks++;
        if ({err, ram_dump, d_rdata} !== {1'b1, 1'b1, 16'h1234}) begin
            errors++; $display("FAIL misalign_done: got err=%b dump=%b rdata=%h required 1 1 1234", err, ram_dump, d_rdata);
        end
        d_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({err, ram_dump} !== 2'b11) begin
            errors++; $display("FAIL misalign_sticky: got %b required 11", {err, ram_dump});
        end
    endtask

    task automatic test_reset_mid_access();
        int cyc, en, wr;
        bit seen;
        if_req = 1'b1; if_addr = 16'h0010;
        repeat (2) @(negedge clk);
        rst = 1'b1; if_req = 1'b0;
        #1;
        checks++;
        if ({if_rdata, d_rdata, ram_addr, ram_wdata} !== 64'h0) begin
            errors++; $display("FAIL rstmid_data: got %h required 0", {if_rdata, d_rdata, ram_addr, ram_wdata});
        end
        checks++;
        if ({if_done, d_done, if_stall, d_stall, ram_en, ram_wr, ram_dump, err} !== 8'h00) begin
            errors++; $display("FAIL rstmid_ctrl: got %b required 00000000", {if_done, d_done, if_stall, d_stall, ram_en, ram_wr, ram_dump, err});
        end
        @(negedge clk);
        rst = 1'b0;
        en = 0; wr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ram_en) en++;
            if (if_done) wr++;
        end
        checks++;
        if (en != 0 || wr != 0) begin
            errors++; $display("FAIL rstmid_no_pulse: ram_en=%0d done=%0d required 0/0", en, wr);
        end
        halt = 1'b1;
        #1;
        checks++;
        if (ram_dump !== 1'b1) begin
            errors++; $display("FAIL halt_dump: got %b required 1", ram_dump);
        end
        halt = 1'b0;
        if_req = 1'b1;
        wait_done(P_IF, 20, cyc, en, wr, seen);
        checks++;
        if (!seen || cyc != LAT + 1 || en != 1 || if_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL rstmid_fresh: seen=%0d cycles=%0d en=%0d rdata=%h required 1/%0d/1/beef", seen, cyc, en, if_rdata, LAT + 1);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    // Randomized traffic on both ports against a transaction-level model.
    task automatic test_random();
        logic [15:0] shadow [1024];
        int          free_edge, out_g, streak_m;
        bit          out_valid, out_port, out_wr, if_act, d_act;
        bit          exp_if_done, exp_d_done, exp_en;
        logic [15:0] out_addr, out_data, exp_if, exp_d;
        for (int a = 0; a < 1024; a++) begin
            shadow[a] = written[a] ? mem[a] : init_val(10'(a));
        end
        do_reset();
        free_edge = 0; out_g = 0; streak_m = 0;
        out_valid = 1'b0; out_port = P_IF; out_wr = 1'b0; if_act = 1'b0; d_act = 1'b0;
        out_addr = 16'h0000; out_data = 16'h0000; exp_if = 16'h0000; exp_d = 16'h0000;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            exp_if_done = out_valid && (out_port == P_IF) && (i == out_g + LAT + 1);
            exp_d_done  = out_valid && (out_port == P_D)  && (i == out_g + LAT + 1);
            exp_en      = out_valid && (i == out_g + LAT) && !out_addr[0];
            if ((exp_if_done || exp_d_done) && !out_wr) begin
                if (out_port == P_IF) exp_if = out_data;
                else exp_d = out_data;
            end
            checks++;
            if ({if_done, d_done, ram_en, ram_wr, err} !== {exp_if_done, exp_d_done, exp_en, exp_en && out_wr, 1'b0}) begin
                errors++; $display("FAIL rand_ctrl edge %0d: got if_done,d_done,en,wr,err=%b required %b", i,
                    {if_done, d_done, ram_en, ram_wr, err}, {exp_if_done, exp_d_done, exp_en, exp_en && out_wr, 1'b0});
            end
            checks++;
            if ({if_rdata, d_rdata} !== {exp_if, exp_d}) begin
                errors++; $display("FAIL rand_rdata edge %0d: got %h required %h", i, {if_rdata, d_rdata}, {exp_if, exp_d});
            end
            if (exp_en) begin
                checks++;
                if (ram_addr !== out_addr || (out_wr && ram_wdata !== out_data)) begin
                    errors++; $display("FAIL rand_ram_bus edge %0d: got addr %h data %h required %h %h", i, ram_addr, ram_wdata, out_addr, out_data);
                end
            end
            if (exp_if_done) begin if_act = 1'b0; out_valid = 1'b0; end
            if (exp_d_done)  begin d_act = 1'b0;  out_valid = 1'b0; end
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1'b1;
                if_addr = 16'($urandom_range(32, 511)) << 1;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1'b1;
                d_wr = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom_range(32, 511)) << 1;
                d_wdata = 16'($urandom);
            end
            if_req = if_act; d_req = d_act;
            #1;
            checks++;
            if ({if_stall, d_stall} !== {if_req && !exp_if_done, d_req && !exp_d_done}) begin
                errors++; $display("FAIL rand_stall edge %0d: got %b required %b", i, {if_stall, d_stall},
                    {if_req && !exp_if_done, d_req && !exp_d_done});
            end
            if (i >= free_edge && (if_req || d_req)) begin
                if (d_req && (!if_req || streak_m < MAXS)) begin
                    out_port = P_D; out_addr = d_addr; out_wr = d_wr;
                    if (d_wr) begin
                        shadow[d_addr[9:0]] = d_wdata;
                        out_data = d_wdata;
                    end else begin
                        out_data = shadow[d_addr[9:0]];
                    end
                    streak_m = if_req ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
                end else begin
                    out_port = P_IF; out_addr = if_addr; out_wr = 1'b0;
                    out_data = shadow[if_addr[9:0]];
                    streak_m = 0;
                end
                out_valid = 1'b1; out_g = i; free_edge = i + LAT + 2;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic test_latency1_back_to_back();
        int n, cyc, last, en;
        logic [15:0] cur;
        cur = 16'h0040;
        if_req1 = 1'b1; if_addr1 = cur;
        n = 0; cyc = 0; last = 0; en = 0;
        while (n < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ram_en1) en++;
            if (if_done1) begin
                checks++;
                if ((cyc - last) != ((n == 0) ? 2 : 3)) begin
                    errors++; $display("FAIL lat1_spacing #%0d: got %0d required %0d", n, cyc - last, (n == 0) ? 2 : 3);
                end
                checks++;
                if (if_rdata1 !== (cur ^ 16'h5A5A)) begin
                    errors++; $display("FAIL lat1_rdata #%0d: got %h required %h", n, if_rdata1, cur ^ 16'h5A5A);
                end
                last = cyc; n++;
                cur = 16'($urandom_range(0, 32767)) << 1;
                if_addr1 = cur;
            end
        end
        if_req1 = 1'b0;
        checks++;
        if (n != 6 || en != n) begin
            errors++; $display("FAIL lat1_count: got %0d completions %0d strobes required 6 6", n, en);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bk_we = 1'b0; bk_addr = 10'h000; bk_data = 16'h0000;
        if_req1 = 1'b0; if_addr1 = 16'h0000;
        test_reset();
        test_fetch_basic();
        test_write_read();
        test_streak();
        test_misaligned();
        test_reset_mid_access();
        test_random();
        test_latency1_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
